// File: rtl/sprite_rom_arbiter.sv
// ---------------------------------------------------------------------------
// SpriteRomArbiter
//
// Shares one block ROM among NREQ sprite/overlay readers. Each cycle at most
// one requester is granted. The grant and the granted address are registered
// on the same edge that sampled the requests. The grant tag then travels down
// a READ_LAT-deep pipeline, so that the tag lines up with the ROM data when
// that data comes back.
//
// Arbitration is round-robin. The search starts one past the last winner.
// When i_prio_en is high, requester 0 (the game-end overlay) wins whenever it
// is requesting.
//
// Ports
//   i_clk       sole clock, rising edge
//   i_rst       synchronous reset, active-high
//   i_req       per-requester level request (NREQ bits)
//   i_addr      packed per-requester addresses; requester k owns
//               bits [k*ADDR_W +: ADDR_W]
//   i_prio_en   give requester 0 absolute priority
//   i_pause     suppress new grants (reads already in flight still finish)
//   o_gnt       registered one-hot-or-zero grant pulse
//   o_rom_addr  registered ROM address (holds when nothing is granted)
//   i_rom_dout  ROM data, valid READ_LAT cycles after o_rom_addr
//   o_rd_data   ROM data passed straight through
//   o_rd_valid  one-hot-or-zero owner of o_rd_data (o_gnt delayed READ_LAT)
//   o_busy      any grant or read still in flight
// ---------------------------------------------------------------------------
module sprite_rom_arbiter #(
  parameter int NREQ     = 4,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 12,
  parameter int READ_LAT = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NREQ-1:0]        i_req,
  input  logic [NREQ*ADDR_W-1:0] i_addr,
  input  logic                   i_prio_en,
  input  logic                   i_pause,
  output logic [NREQ-1:0]        o_gnt,
  output logic [ADDR_W-1:0]      o_rom_addr,
  input  logic [DATA_W-1:0]      i_rom_dout,
  output logic [DATA_W-1:0]      o_rd_data,
  output logic [NREQ-1:0]        o_rd_valid,
  output logic                   o_busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);

  logic [PTR_W-1:0]  r_ptr;
  logic [NREQ-1:0]   r_gnt;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [NREQ-1:0]   r_tag [READ_LAT];

  logic [ADDR_W-1:0] w_addr_arr [NREQ];
  logic              w_found;
  logic [PTR_W-1:0]  w_winner;
  logic [PTR_W-1:0]  w_idx;
  logic [NREQ-1:0]   w_gnt_next;
  logic              w_busy;

  // Unpack the flat address bus into one address per requester.
  for (genvar k = 0; k < NREQ; k++) begin : g_addr
    assign w_addr_arr[k] = i_addr[k*ADDR_W +: ADDR_W];
  end

  // Pick this cycle's winner. Pause blocks every grant. With priority enabled,
  // a requesting requester 0 wins outright. Otherwise the first active request
  // wins, searching upward from one past the last winner and wrapping. The
  // last winner itself is visited last, so it only gets a back-to-back grant
  // when no other requester is active.
  always_comb begin
    w_found  = 1'b0;
    w_winner = LAST_IDX;
    w_idx    = '0;
    if (!i_pause) begin
      if (i_prio_en && i_req[0]) begin
        w_found  = 1'b1;
        w_winner = '0;
      end else begin
        for (int i = 1; i <= NREQ; i++) begin
          w_idx = PTR_W'((int'(r_ptr) + i) % NREQ);
          if (!w_found && i_req[w_idx]) begin
            w_found  = 1'b1;
            w_winner = w_idx;
          end
        end
      end
    end
  end

  assign w_gnt_next = w_found ? (NREQ'(1) << w_winner) : '0;

  // Register the grant and its address on the sampling edge. The address and
  // the round-robin pointer change only on a real grant, so the ROM address
  // holds steady while idle or paused. After reset the pointer sits at the top
  // index, so requester 0 is searched first.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_gnt      <= '0;
      r_rom_addr <= '0;
      r_ptr      <= LAST_IDX;
    end else begin
      r_gnt <= w_gnt_next;
      if (w_found) begin
        r_rom_addr <= w_addr_arr[w_winner];
        r_ptr      <= w_winner;
      end
    end
  end

  // Delay the grant tag by the ROM latency so it marks the owner of the data
  // when it returns. Reset flushes the pipeline, which drops any read that was
  // in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int s = 0; s < READ_LAT; s++) begin
        r_tag[s] <= '0;
      end
    end else begin
      r_tag[0] <= r_gnt;
      for (int s = 1; s < READ_LAT; s++) begin
        r_tag[s] <= r_tag[s-1];
      end
    end
  end

  // Busy covers the grant stage plus every tag stage still in flight.
  always_comb begin
    w_busy = |r_gnt;
    for (int s = 0; s < READ_LAT; s++) begin
      w_busy = w_busy | (|r_tag[s]);
    end
  end

  assign o_gnt      = r_gnt;
  assign o_rom_addr = r_rom_addr;
  assign o_rd_valid = r_tag[READ_LAT-1];
  assign o_rd_data  = i_rom_dout;
  assign o_busy     = w_busy;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// ---------------------------------------------------------------------------
// TbSpriteRomArbiter
//
// Directed bench for sprite_rom_arbiter with NREQ=4, ADDR_W=16, DATA_W=12 and
// READ_LAT=2. A small two-stage ROM model returns addr[11:0] ^ 12'hA5C, so
// every returned pixel has a hand-computable value:
//   0A00 -> 05C, 1234 -> 868, 2C00 -> 65C, FFFF -> 5A3, 3ABC -> 0E0
// ---------------------------------------------------------------------------
module tb_sprite_rom_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] addr0, addr1, addr2, addr3;
  logic [63:0] addrBus;
  logic        prioEn;
  logic        pause;
  logic [3:0]  gnt;
  logic [15:0] romAddr;
  logic [11:0] romDout;
  logic [11:0] rdData;
  logic [3:0]  rdValid;
  logic        busy;

  logic [11:0] romPipe1;
  logic [11:0] romPipe2;

  int total;
  int bad;

  logic [3:0]  expGnt  [5];
  logic [15:0] expAddr [5];
  logic [3:0]  expRv   [5];
  logic [11:0] expRd   [5];

  assign addrBus = {addr3, addr2, addr1, addr0};

  sprite_rom_arbiter #(
    .NREQ(4), .ADDR_W(16), .DATA_W(12), .READ_LAT(2)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_req(req),
    .i_addr(addrBus),
    .i_prio_en(prioEn),
    .i_pause(pause),
    .o_gnt(gnt),
    .o_rom_addr(romAddr),
    .i_rom_dout(romDout),
    .o_rd_data(rdData),
    .o_rd_valid(rdValid),
    .o_busy(busy)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-cycle ROM model: data for the address registered at edge N appears
  // after edge N+2.
  function automatic logic [11:0] romFunc(input logic [15:0] a);
    return a[11:0] ^ 12'hA5C;
  endfunction

  always @(posedge clk) begin
    romPipe1 <= romFunc(romAddr);
    romPipe2 <= romPipe1;
  end
  assign romDout = romPipe2;

  // Drive the control inputs, then advance one edge and settle past it.
  task automatic applyStimulus(input logic [3:0] r, input logic p, input logic ps, input logic rs);
    req    = r;
    prioEn = p;
    pause  = ps;
    rst    = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    addr0 = 16'h0A00;
    addr1 = 16'h1234;
    addr2 = 16'h2C00;
    addr3 = 16'hFFFF;
    req = 4'b0000; prioEn = 1'b0; pause = 1'b0; rst = 1'b1;

    // Reset state
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_gnt",     32'(gnt),     32'h0);
    checkOutput("rst_romaddr", 32'(romAddr), 32'h0);
    checkOutput("rst_rdvalid", 32'(rdValid), 32'h0);
    checkOutput("rst_busy",    32'(busy),    32'h0);

    // Round-robin with every requester active
    $display("[TB] round-robin, all requesting");
    expGnt[0] = 4'b0001; expAddr[0] = 16'h0A00; expRv[0] = 4'b0000; expRd[0] = 12'h000;
    expGnt[1] = 4'b0010; expAddr[1] = 16'h1234; expRv[1] = 4'b0000; expRd[1] = 12'h000;
    expGnt[2] = 4'b0100; expAddr[2] = 16'h2C00; expRv[2] = 4'b0001; expRd[2] = 12'h05C;
    expGnt[3] = 4'b1000; expAddr[3] = 16'hFFFF; expRv[3] = 4'b0010; expRd[3] = 12'h868;
    expGnt[4] = 4'b0001; expAddr[4] = 16'h0A00; expRv[4] = 4'b0100; expRd[4] = 12'h65C;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("rr_gnt%0d", i),     32'(gnt),     32'(expGnt[i]));
      checkOutput($sformatf("rr_romaddr%0d", i), 32'(romAddr), 32'(expAddr[i]));
      checkOutput($sformatf("rr_rdvalid%0d", i), 32'(rdValid), 32'(expRv[i]));
      if (i >= 2) begin
        checkOutput($sformatf("rr_rddata%0d", i), 32'(rdData), 32'(expRd[i]));
      end
      checkOutput($sformatf("rr_busy%0d", i), 32'(busy), 32'h1);
    end

    // Priority overlay starves requester 2
    $display("[TB] priority on requester 0");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'b0101, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("prio_gnt%0d", i), 32'(gnt), 32'b0001);
    end
    applyStimulus(4'b0101, 1'b0, 1'b0, 1'b0);
    checkOutput("prio_off_gnt",     32'(gnt),     32'b0100);
    checkOutput("prio_off_romaddr", 32'(romAddr), 32'h2C00);
    applyStimulus(4'b0101, 1'b0, 1'b0, 1'b0);
    checkOutput("prio_off_gnt2",    32'(gnt),     32'b0001);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("idle_gnt",     32'(gnt),     32'h0);
    checkOutput("idle_romaddr", 32'(romAddr), 32'h0A00);
    checkOutput("prio_rv2",     32'(rdValid), 32'b0100);
    checkOutput("prio_rd2",     32'(rdData),  32'h65C);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("prio_rv0", 32'(rdValid), 32'b0001);
    checkOutput("prio_rd0", 32'(rdData),  32'h05C);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("drain_rv",   32'(rdValid), 32'h0);
    checkOutput("drain_busy", 32'(busy),    32'h0);

    // Single read from requester 1, two-cycle latency
    $display("[TB] single read");
    applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
    checkOutput("single_gnt",     32'(gnt),     32'b0010);
    checkOutput("single_romaddr", 32'(romAddr), 32'h1234);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("single_gnt_off", 32'(gnt),     32'h0);
    checkOutput("single_rv_early", 32'(rdValid), 32'h0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("single_rv",   32'(rdValid), 32'b0010);
    checkOutput("single_rd",   32'(rdData),  32'h868);
    checkOutput("single_busy", 32'(busy),    32'h1);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("single_rv_off", 32'(rdValid), 32'h0);
    checkOutput("single_idle",   32'(busy),    32'h0);

    // Pause with one read in flight
    $display("[TB] pause");
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    checkOutput("pause_pre_gnt", 32'(gnt), 32'b0100);
    applyStimulus(4'b0011, 1'b0, 1'b1, 1'b0);
    checkOutput("pause1_gnt",     32'(gnt),     32'h0);
    checkOutput("pause1_romaddr", 32'(romAddr), 32'h2C00);
    checkOutput("pause1_busy",    32'(busy),    32'h1);
    applyStimulus(4'b0011, 1'b0, 1'b1, 1'b0);
    checkOutput("pause2_gnt",  32'(gnt),     32'h0);
    checkOutput("pause2_rv",   32'(rdValid), 32'b0100);
    checkOutput("pause2_rd",   32'(rdData),  32'h65C);
    applyStimulus(4'b0011, 1'b0, 1'b1, 1'b0);
    checkOutput("pause3_gnt",  32'(gnt),     32'h0);
    checkOutput("pause3_busy", 32'(busy),    32'h0);
    applyStimulus(4'b0011, 1'b0, 1'b0, 1'b0);
    checkOutput("resume_gnt0",     32'(gnt),     32'b0001);
    checkOutput("resume_romaddr0", 32'(romAddr), 32'h0A00);
    applyStimulus(4'b0011, 1'b0, 1'b0, 1'b0);
    checkOutput("resume_gnt1",     32'(gnt),     32'b0010);

    // Reset one cycle after a grant drops the read
    $display("[TB] reset during flight");
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
    checkOutput("preRst_gnt", 32'(gnt), 32'b0001);
    applyStimulus(4'b1000, 1'b0, 1'b0, 1'b1);
    checkOutput("midRst_gnt",     32'(gnt),     32'h0);
    checkOutput("midRst_rv",      32'(rdValid), 32'h0);
    checkOutput("midRst_busy",    32'(busy),    32'h0);
    checkOutput("midRst_romaddr", 32'(romAddr), 32'h0);
    applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
    checkOutput("postRst_gnt",     32'(gnt),     32'b1000);
    checkOutput("postRst_romaddr", 32'(romAddr), 32'hFFFF);
    checkOutput("postRst_rv",      32'(rdValid), 32'h0);

    // Lone requester 3 streams back-to-back
    $display("[TB] lone requester streaming");
    applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
    checkOutput("stream_gnt1", 32'(gnt),     32'b1000);
    checkOutput("stream_rv1",  32'(rdValid), 32'h0);
    applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
    checkOutput("stream_gnt2", 32'(gnt),     32'b1000);
    checkOutput("stream_rv2",  32'(rdValid), 32'b1000);
    checkOutput("stream_rd2",  32'(rdData),  32'h5A3);
    addr3 = 16'h3ABC;
    applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
    checkOutput("stream_gnt3",     32'(gnt),     32'b1000);
    checkOutput("stream_romaddr3", 32'(romAddr), 32'h3ABC);
    checkOutput("stream_rv3",      32'(rdValid), 32'b1000);
    applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
    checkOutput("stream_rd4", 32'(rdData), 32'h5A3);
    applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
    checkOutput("stream_rd5",   32'(rdData),  32'h0E0);
    checkOutput("stream_rv5",   32'(rdValid), 32'b1000);
    checkOutput("stream_busy5", 32'(busy),    32'h1);

    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
